// File: rtl/hdmi_frame_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_fetch_pkg
// Shared types and constants for the HDMI frame fetch controller.
//   fetch_state_e : scheduler FSM states
//   FRAME_PIX     : pixels per frame for the default 1920x1080 raster
//   RD_LEN_W      : width of the read-length field (holds 1..BURST_LEN)
//   PIX_CNT_W     : width of the remaining-pixel counter
//   burst_len()   : min(burst limit, pixels left) narrowed to RD_LEN_W
// -----------------------------------------------------------------------------
package hdmi_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_VS = 3'd1,
        FLUSH   = 3'd2,
        ARM     = 3'd3,
        REQ     = 3'd4,
        BUSY    = 3'd5
    } fetch_state_e;

    localparam int unsigned H_ACTIVE_DEF = 1920;
    localparam int unsigned V_ACTIVE_DEF = 1080;
    localparam int unsigned FRAME_PIX    = H_ACTIVE_DEF * V_ACTIVE_DEF;
    localparam int unsigned RD_LEN_W     = 9;
    localparam int unsigned PIX_CNT_W    = 32;

    // Length of the next burst: whole bursts until the tail of the frame.
    function automatic logic [RD_LEN_W-1:0] burst_len(
        input logic [PIX_CNT_W-1:0] pix_left,
        input logic [PIX_CNT_W-1:0] burst_max
    );
        logic [PIX_CNT_W-1:0] len_full;
        if (pix_left < burst_max) begin
            len_full = pix_left;
        end else begin
            len_full = burst_max;
        end
        return len_full[RD_LEN_W-1:0];
    endfunction

endpackage

// File: rtl/hdmi_frame_fetch_ctrl_sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Registers a level input once and produces a one-cycle pulse on its rising
// edge (seen one cycle after the input rises).
//   clk_i  : clock
//   rst_i  : synchronous reset, active-high
//   sig_i  : level input (e.g. vertical sync)
//   rise_o : rising-edge pulse
// -----------------------------------------------------------------------------
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;
    logic sig_dly_q;

    // Input register and its one-cycle delayed copy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sig_q     <= 1'b0;
            sig_dly_q <= 1'b0;
        end else begin
            sig_q     <= sig_i;
            sig_dly_q <= sig_q;
        end
    end

    assign rise_o = sig_q & ~sig_dly_q;

endmodule

// File: rtl/hdmi_frame_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// hdmi_frame_fetch_ctrl
// Frame-synchronous read scheduler for the pixel FIFO feeding the HDMI TX.
// At each vsync rising edge the FIFO is flushed and addressing restarts at
// I_Base_Addr; bursts of up to BURST_LEN pixels are then requested whenever
// the FIFO has room. Only one burst is ever outstanding.
//   Pixl_CLK / Rst_Posedge          : pixel clock, sync active-high reset
//   I_Enable                        : fetch enable (level)
//   I_Base_Addr                     : frame base, sampled at frame start
//   I_VGA_Sync, I_Pixel_Active      : TX vsync and pixel pop strobe
//   I_Fifo_Level, I_Fifo_Empty      : pixel FIFO status
//   O_Fifo_Flush                    : one-cycle FIFO clear
//   O_Rd_Req/Addr/Len, I_Rd_Ack/Done: memory reader handshake
//   O_Frame_Start, O_Frame_Cnt      : frame restart pulse and counter
//   O_Underflow                     : sticky pop-while-empty flag
//   O_Busy                          : FSM not idle
// -----------------------------------------------------------------------------
module hdmi_frame_fetch_ctrl
    import hdmi_fetch_pkg::*;
#(
    parameter int unsigned H_ACTIVE      = 1920,
    parameter int unsigned V_ACTIVE      = 1080,
    parameter int unsigned BURST_LEN     = 256,
    parameter int unsigned BYTES_PER_PIX = 4,
    parameter int unsigned FIFO_DEPTH    = 4096,
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned LVL_W         = 13
) (
    input  logic                Pixl_CLK,
    input  logic                Rst_Posedge,
    input  logic                I_Enable,
    input  logic [ADDR_W-1:0]   I_Base_Addr,
    input  logic                I_VGA_Sync,
    input  logic                I_Pixel_Active,
    input  logic [LVL_W-1:0]    I_Fifo_Level,
    input  logic                I_Fifo_Empty,
    output logic                O_Fifo_Flush,
    output logic                O_Rd_Req,
    output logic [ADDR_W-1:0]   O_Rd_Addr,
    output logic [RD_LEN_W-1:0] O_Rd_Len,
    input  logic                I_Rd_Ack,
    input  logic                I_Rd_Done,
    output logic                O_Frame_Start,
    output logic [15:0]         O_Frame_Cnt,
    output logic                O_Underflow,
    output logic                O_Busy
);

    localparam logic [PIX_CNT_W-1:0] FRAME_PIX_L = PIX_CNT_W'(H_ACTIVE * V_ACTIVE);
    localparam logic [PIX_CNT_W-1:0] BURST_MAX   = PIX_CNT_W'(BURST_LEN);
    localparam logic [LVL_W:0]       DEPTH_X     = (LVL_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0]    BPP_X       = ADDR_W'(BYTES_PER_PIX);

    fetch_state_e          state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [PIX_CNT_W-1:0]  pix_left_q, pix_left_d;
    logic [RD_LEN_W-1:0]   len_q, len_d;
    logic                  pend_vs_q, pend_vs_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  underflow_q, underflow_d;
    logic                  flush_q, flush_d;
    logic                  req_q, req_d;
    logic                  busy_q, busy_d;

    logic                  vs_rise_s;
    logic [LVL_W:0]        level_x_s;
    logic [LVL_W:0]        free_s;
    logic [LVL_W:0]        len_x_s;

    sync_edge_det u_vs_edge (
        .clk_i  (Pixl_CLK),
        .rst_i  (Rst_Posedge),
        .sig_i  (I_VGA_Sync),
        .rise_o (vs_rise_s)
    );

    // Free FIFO space; a level above the depth is treated as no room.
    always_comb begin
        level_x_s = {1'b0, I_Fifo_Level};
        if (level_x_s > DEPTH_X) begin
            free_s = {(LVL_W + 1){1'b0}};
        end else begin
            free_s = DEPTH_X - level_x_s;
        end
    end

    // Next-state and datapath logic of the fetch scheduler.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pix_left_d  = pix_left_q;
        len_d       = len_q;
        pend_vs_d   = pend_vs_q;
        frame_cnt_d = frame_cnt_q;
        underflow_d = underflow_q |
                      (I_Pixel_Active & I_Fifo_Empty & (state_q != IDLE));
        len_x_s     = {(LVL_W + 1){1'b0}};

        case (state_q)
            IDLE: begin
                if (I_Enable) begin
                    state_d = WAIT_VS;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_VS: begin
                if (vs_rise_s) begin
                    state_d = FLUSH;
                end else if (!I_Enable) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_VS;
                end
            end
            FLUSH: begin
                addr_d     = I_Base_Addr;
                pix_left_d = FRAME_PIX_L;
                pend_vs_d  = 1'b0;
                state_d    = ARM;
            end
            ARM: begin
                len_d   = burst_len(pix_left_q, BURST_MAX);
                len_x_s = (LVL_W + 1)'(len_d);
                // A vsync seen now or during the last transaction resyncs first.
                if (pend_vs_q || vs_rise_s) begin
                    state_d = FLUSH;
                end else if (pix_left_q == {PIX_CNT_W{1'b0}}) begin
                    if (I_Enable) begin
                        state_d = WAIT_VS;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!I_Enable) begin
                    state_d = IDLE;
                end else if (free_s >= len_x_s) begin
                    state_d = REQ;
                end else begin
                    state_d = ARM;
                end
            end
            REQ: begin
                if (vs_rise_s) begin
                    pend_vs_d = 1'b1;
                end else begin
                    pend_vs_d = pend_vs_q;
                end
                if (I_Rd_Ack) begin
                    state_d = BUSY;
                end else begin
                    state_d = REQ;
                end
            end
            BUSY: begin
                if (vs_rise_s) begin
                    pend_vs_d = 1'b1;
                end else begin
                    pend_vs_d = pend_vs_q;
                end
                if (I_Rd_Done) begin
                    addr_d     = addr_q + (ADDR_W'(len_q) * BPP_X);
                    pix_left_d = pix_left_q - PIX_CNT_W'(len_q);
                    state_d    = ARM;
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == FLUSH) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end

        flush_d = (state_d == FLUSH);
        req_d   = (state_d == REQ);
        busy_d  = (state_d != IDLE);
    end

    // State, datapath and registered-output flops.
    always_ff @(posedge Pixl_CLK) begin
        if (Rst_Posedge) begin
            state_q     <= IDLE;
            addr_q      <= {ADDR_W{1'b0}};
            pix_left_q  <= {PIX_CNT_W{1'b0}};
            len_q       <= {RD_LEN_W{1'b0}};
            pend_vs_q   <= 1'b0;
            frame_cnt_q <= 16'd0;
            underflow_q <= 1'b0;
            flush_q     <= 1'b0;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pix_left_q  <= pix_left_d;
            len_q       <= len_d;
            pend_vs_q   <= pend_vs_d;
            frame_cnt_q <= frame_cnt_d;
            underflow_q <= underflow_d;
            flush_q     <= flush_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
        end
    end

    assign O_Fifo_Flush  = flush_q;
    assign O_Frame_Start = flush_q;
    assign O_Rd_Req      = req_q;
    assign O_Rd_Addr     = addr_q;
    assign O_Rd_Len      = len_q;
    assign O_Frame_Cnt   = frame_cnt_q;
    assign O_Underflow   = underflow_q;
    assign O_Busy        = busy_q;

endmodule

// File: doc/hdmi_frame_fetch_ctrl.md
Name: hdmi_frame_fetch_ctrl

Overview:
Frame-synchronous read scheduler feeding the pixel FIFO that supplies I_Pixel_Data to the HDMI transmitter.
- Issues burst read requests to the memory reader, gated by FIFO free space.
- Restarts addressing at each frame start.
- Flags pixel underflow during active video.
- Runs in the pixel clock domain, between the memory reader/FIFO and the TX timing outputs (O_Pixel_Active, O_VGA_Sync).

Parameters:
H_ACTIVE, 1920, active pixels per line
V_ACTIVE, 1080, active lines per frame
BURST_LEN, 256, max pixels per read request
BYTES_PER_PIX, 4, address increment per pixel
FIFO_DEPTH, 4096, pixel FIFO depth in pixels
ADDR_W, 32, memory address width
LVL_W, 13, FIFO level width (must hold FIFO_DEPTH)

Ports:
Pixl_CLK  in  1  pixel clock
Rst_Posedge  in  1  synchronous reset, active-high
I_Enable  in  1  fetch enable, level
I_Base_Addr  in  ADDR_W  frame base address, sampled at frame start
I_VGA_Sync  in  1  TX vertical sync, active-high
I_Pixel_Active  in  1  TX pixel pop strobe (DE)
I_Fifo_Level  in  LVL_W  pixel FIFO occupancy
I_Fifo_Empty  in  1  pixel FIFO empty
O_Fifo_Flush  out  1  one-cycle FIFO clear pulse
O_Rd_Req  out  1  read request
O_Rd_Addr  out  ADDR_W  request byte address
O_Rd_Len  out  9  request length in pixels (1..BURST_LEN)
I_Rd_Ack  in  1  request accepted
I_Rd_Done  in  1  burst data fully written to FIFO
O_Frame_Start  out  1  one-cycle pulse at frame restart
O_Frame_Cnt  out  16  frames started, wraps at 0xFFFF->0
O_Underflow  out  1  sticky underflow flag
O_Busy  out  1  high when state is not IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, pixel counter 0, address 0. Reset mid-burst drops the transaction silently; the reader is reset by the same source.
- Vsync rising edge (vs_rise): I_VGA_Sync registered once; vs_rise = sync & !sync_d. Adds one cycle of latency.
- FSM states:
  - IDLE: on I_Enable -> WAIT_VS.
  - WAIT_VS: on vs_rise -> FLUSH. If !I_Enable -> IDLE.
  - FLUSH (1 cycle):
    - O_Fifo_Flush=1, O_Frame_Start=1, O_Frame_Cnt++.
    - addr <= I_Base_Addr; pix_left <= H_ACTIVE*V_ACTIVE.
    - -> ARM.
  - ARM: if pending_vs -> FLUSH. Else if pix_left==0 or !I_Enable -> WAIT_VS / IDLE. Else if FIFO_DEPTH - I_Fifo_Level >= len -> REQ.
    - len = min(BURST_LEN, pix_left).
  - REQ: O_Rd_Req=1; O_Rd_Addr and O_Rd_Len held stable until I_Rd_Ack. On ack -> BUSY, O_Rd_Req deasserts the next cycle. A request is never withdrawn before ack.
  - BUSY: on I_Rd_Done -> addr += len*BYTES_PER_PIX, pix_left -= len -> ARM.
- Space check uses I_Fifo_Level at the ARM cycle. The FIFO level must already include all prior done bursts, so only one burst is ever outstanding.
- pending_vs: set on vs_rise in ARM/REQ/BUSY; cleared in FLUSH. A vsync during a transaction finishes that transaction (ack then done) and then resyncs via FLUSH. The remaining pixels of the old frame are abandoned.
- vs_rise and I_Rd_Done in the same cycle: done is processed first, pending_vs set, next ARM -> FLUSH.
- I_Enable dropped mid-transaction: finish through BUSY, then ARM -> IDLE. No flush.
- Underflow: I_Pixel_Active & I_Fifo_Empty while state != IDLE sets O_Underflow. Cleared only by reset.
- Last burst of a frame: O_Rd_Len = remainder when H_ACTIVE*V_ACTIVE is not a multiple of BURST_LEN.
- Address arithmetic wraps modulo 2^ADDR_W. No overflow check.

Decomposition:
- Package hdmi_fetch_pkg holds:
  - state enum (IDLE, WAIT_VS, FLUSH, ARM, REQ, BUSY)
  - FRAME_PIX constant
  - O_Rd_Len width constant
- One sub-module is natural: sync_edge_det (register plus rising-edge pulse for I_VGA_Sync). Reusable for the TX timing pulses.

Test Plan:
1. Reset, enable, vsync pulse, FIFO level 0, ack/done 4 cycles after each req -> Flush/Frame_Start pulse once, Frame_Cnt=1. 8100 requests, all len 256, addrs Base+0, +1024, ... Final addr Base+8293376, then WAIT_VS.
2. FIFO level held at 3900 -> no O_Rd_Req (free 196 < 256). Drop level to 3840 -> req issued next ARM cycle.
3. V_ACTIVE=1, H_ACTIVE=600 -> lens 256, 256, 88, then WAIT_VS.
4. Vsync during BUSY, done arrives 10 cycles later -> one more ARM cycle, FLUSH, addr reloads I_Base_Addr, Frame_Cnt increments.
5. Ack withheld 50 cycles -> O_Rd_Req, addr and len stable throughout. Enable dropped meanwhile -> burst completes, then IDLE, O_Busy=0.
6. I_Pixel_Active=1 with I_Fifo_Empty=1 for 1 cycle -> O_Underflow=1 and stays 1 across the next frame until reset.
